// File: rtl/pipe_hazard_seq_if.sv
// Signal bundle between the ID/EX pipeline stages and the sequencing controller.
// Every signal is a level that is sampled every cycle. There is no valid/ready pairing.
interface pipe_hazard_seq_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       id_opcode;
  logic [5:0]       id_func;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [1:0]       ex_mem2reg_sel;
  logic             ex_reg_write;
  logic [4:0]       ex_dst;
  logic             ex_branch_taken;

  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       dbg_state;

  modport master (
    output id_opcode, id_func, id_rs, id_rt,
    output ex_mem2reg_sel, ex_reg_write, ex_dst, ex_branch_taken,
    input  pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, halted,
    input  stall_cnt, flush_cnt, dbg_state
  );

  modport slave (
    input  id_opcode, id_func, id_rs, id_rt,
    input  ex_mem2reg_sel, ex_reg_write, ex_dst, ex_branch_taken,
    output pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, halted,
    output stall_cnt, flush_cnt, dbg_state
  );
endinterface

// File: rtl/pipe_hazard_seq.sv
// Pipeline sequencing controller: load-use stalls, branch/jump redirects,
// and the STOP drain/halt sequence, with saturating stall and flush counters.
module pipe_hazard_seq #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       drain_cnt;
  logic             boot;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic uses_rs, uses_rt, is_j, is_jr, is_stop, load_use;
  logic forced, stall_inc, flush_inc, stop_accept;

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    if (bus.id_opcode == 6'd0) begin
      uses_rs = !(bus.id_func inside {6'd0, 6'd2, 6'd3});
      uses_rt = (bus.id_func != 6'd8);
    end else begin
      uses_rs = bus.id_opcode inside {6'd4, 6'd5, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43};
      uses_rt = bus.id_opcode inside {6'd4, 6'd5, 6'd43};
    end
    is_j    = (bus.id_opcode == 6'd2) || (bus.id_opcode == 6'd3);
    is_jr   = (bus.id_opcode == 6'd0) && (bus.id_func == 6'd8);
    is_stop = (bus.id_opcode == 6'd63);
    load_use = (bus.ex_mem2reg_sel == 2'd1) && bus.ex_reg_write && (bus.ex_dst != 5'd0) &&
               ((uses_rs && (bus.ex_dst == bus.id_rs)) || (uses_rt && (bus.ex_dst == bus.id_rt)));
  end

  // The cycle after reset release is forced too, so the pipe registers settle to bubbles.
  assign forced = rst || boot;

  always_comb begin
    bus.pc_en      = 1'b1;
    bus.ifid_en    = 1'b1;
    bus.pc_sel     = 2'd0;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    bus.halted     = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    stop_accept    = 1'b0;
    if (forced) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.ex_branch_taken) begin
            bus.pc_sel     = 2'd1;
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            flush_inc      = 1'b1;
          end else if (load_use) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
            stall_inc      = 1'b1;
          end else if (is_j || is_jr) begin
            bus.pc_sel     = is_jr ? 2'd3 : 2'd2;
            bus.ifid_flush = 1'b1;
            flush_inc      = 1'b1;
          end else if (is_stop) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
            stop_accept    = 1'b1;
          end
        end
        default: begin
          bus.pc_en      = 1'b0;
          bus.ifid_en    = 1'b0;
          bus.idex_flush = 1'b1;
          bus.halted     = (state == ST_HALT);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= 4'd0;
      boot      <= 1'b1;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      boot <= 1'b0;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
      case (state)
        ST_RUN: begin
          if (stop_accept) begin
            state     <= ST_DRAIN;
            drain_cnt <= 4'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt == 4'd1) state <= ST_HALT;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
  assign bus.dbg_state = state;

endmodule
